l3_req_arbiter: RTL
===================

L3_REQ_ARBITER -- requirements
Module: l3_req_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 6: number of core request ports.
REQ-002 SHALL have parameter DW, default 16: write-data width, equal to the L3 cell width.
REQ-003 SHALL have parameter AW, fixed at 12: address = {x[5:0], y[5:0]} L3 cell coordinate.
REQ-004 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NPORT: per-core request valid.
REQ-007 SHALL have port req_wr, input, NPORT: per-core write (1) / read (0).
REQ-008 SHALL have port req_addr, input, NPORT*12: packed addresses, port i at [12i+11:12i].
REQ-009 SHALL have port req_wdata, input, NPORT*DW: packed write data, port i at [DW*i+DW-1:DW*i].
REQ-010 SHALL have port req_ready, output, NPORT: per-core accept, one-hot or zero.
REQ-011 SHALL have port l3_valid, output, 1: command to L3 valid.
REQ-012 SHALL have port l3_ready, input, 1: L3 accepts command.
REQ-013 SHALL have port l3_wr, output, 1, plus l3_addr, output, 12, plus l3_wdata, output, DW: command payload.
REQ-014 SHALL have port l3_src, output, 3: index of originating port.
REQ-015 SHALL have port fifo_level, output, 2: output queue occupancy 0..2.
REQ-016 SHALL have port err_pulse, output, 1: one-cycle flag for a dropped out-of-range request.
REQ-017 SHALL have port err_count, output, 8: count of dropped requests, saturating.

Function
REQ-018 SHALL select the winner each cycle as the first asserted req_valid bit scanning upward from rr_ptr, wrapping NPORT-1 to 0.
REQ-019 SHALL assert req_ready only for the winner, and only when fifo_level < 2.
  - req_ready SHALL be independent of l3_ready (no combinational path).
REQ-020 SHALL define acceptance as req_valid[i] && req_ready[i].
  - On acceptance rr_ptr SHALL become (i+1) mod NPORT.
  - Without acceptance rr_ptr SHALL hold.
REQ-021 SHALL push each accepted in-range request into a 2-entry FIFO as {wr, addr, wdata, src}.
REQ-022 SHALL treat an address as in-range iff x<60 and y<60.
REQ-023 SHALL accept out-of-range requests normally but SHALL NOT push them into the FIFO.
  - err_pulse SHALL be high in the following cycle only.
  - err_count SHALL increment by 1, holding at 255 once reached.
REQ-024 SHALL drive l3_valid = (fifo_level != 0), with l3_* showing the FIFO head.
  - Payload SHALL stay stable while l3_valid && !l3_ready.
REQ-025 SHALL pop the FIFO when l3_valid && l3_ready.
  - Push and pop in the same cycle SHALL leave fifo_level unchanged and preserve order.
REQ-026 SHALL have a latency of exactly 1 cycle from acceptance to l3_valid when the FIFO was empty.
REQ-027 SHALL sustain one command per cycle when l3_ready is held high.
REQ-028 SHALL preserve FIFO order: L3 sees commands in acceptance order.
REQ-029 SHALL treat a request held valid and never granted as a bench bug only: round-robin bounds its wait to NPORT-1 grants.

Reset
REQ-030 SHALL, on rst_n low, immediately clear all state to these values:
  - FIFO empty, fifo_level=0, l3_valid=0;
  - l3_wr=0, l3_addr=0, l3_wdata=0, l3_src=0;
  - rr_ptr=0, req_ready=0;
  - err_pulse=0, err_count=0.
REQ-031 SHALL discard any command in flight or queued when reset is asserted mid-operation, with no partial output.
REQ-032 SHALL hold req_ready=0 while rst_n is low.

Verification
REQ-033 SHALL pass single request: port 3 read addr 0x105, l3_ready=1 -> l3_valid next cycle, l3_addr=0x105, l3_src=3, rr_ptr=4.
REQ-034 SHALL pass fairness: all 6 ports valid continuously, l3_ready=1 -> grants 0,1,2,3,4,5,0 on successive cycles.
REQ-035 SHALL pass backpressure: l3_ready=0, ports 0,1 valid -> two acceptances, fifo_level=2, all req_ready=0.
  - Then l3_ready=1 -> l3_src 0 then 1.
REQ-036 SHALL pass out-of-range: port 2 addr x=60 -> accepted, err_pulse one cycle, err_count=1, l3_valid stays 0.
  - 300 such requests -> err_count=255.
REQ-037 SHALL pass mid-reset: FIFO at level 2, rst_n pulsed low -> l3_valid=0 and fifo_level=0 asynchronously.
  - After release, port 5 request is granted first from rr_ptr=0 scan.

Source files
------------

// File: rtl/l3_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l3_req_arbiter
// Purpose  : Round-robin arbiter funnelling per-core L3 requests into a
//            2-entry command queue that drives a single L3 command port.
//            Requests whose cell coordinate lies outside the 60x60 array are
//            accepted (so the core is never stalled) but dropped, raising a
//            one-cycle error pulse and bumping a saturating drop counter.
// Ports    : clk, rst_n          clock / asynchronous active-low reset
//            req_valid[NPORT]    per-core request valid
//            req_wr[NPORT]       per-core write(1)/read(0)
//            req_addr            packed {x[5:0],y[5:0]}, port i at [12i +: 12]
//            req_wdata           packed write data, port i at [DW*i +: DW]
//            req_ready[NPORT]    one-hot (or zero) accept back to the cores
//            l3_valid/l3_ready   command handshake towards L3
//            l3_wr/addr/wdata    command payload (queue head)
//            l3_src              originating port of the queue head
//            fifo_level          command queue occupancy (0..2)
//            err_pulse           one-cycle flag for a dropped request
//            err_count           saturating count of dropped requests
// Revision : 1.0 - initial release
// ============================================================================
module l3_req_arbiter #(
  parameter int NPORT = 6,   // number of core ports, 2..8 (l3_src is 3 bits)
  parameter int DW    = 16,  // write-data width = L3 cell width
  parameter int AW    = 12   // address width, always {x[5:0], y[5:0]}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NPORT-1:0]    req_valid,
  input  logic [NPORT-1:0]    req_wr,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*DW-1:0] req_wdata,
  output logic [NPORT-1:0]    req_ready,
  output logic                l3_valid,
  input  logic                l3_ready,
  output logic                l3_wr,
  output logic [AW-1:0]       l3_addr,
  output logic [DW-1:0]       l3_wdata,
  output logic [2:0]          l3_src,
  output logic [1:0]          fifo_level,
  output logic                err_pulse,
  output logic [7:0]          err_count
);

  localparam int         c_HALF  = AW / 2;
  localparam int         c_ENT_W = 1 + AW + DW + 3;
  localparam logic [2:0] c_LAST  = 3'(NPORT - 1);
  localparam logic [c_HALF-1:0] c_CELL_LIMIT = c_HALF'(60);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]         r_rr_ptr;
  logic [c_ENT_W-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_level;
  logic               r_err_pulse;
  logic [7:0]         r_err_count;

  // --------------------------------------------------------------------------
  // Winner selection
  // The mask keeps ports at or above rr_ptr. The lowest masked request wins;
  // if none is masked the scan has wrapped, so the lowest request overall
  // wins. Both searches run high-to-low so the last hit is the lowest index.
  // --------------------------------------------------------------------------
  logic [NPORT-1:0] w_hi_mask;
  logic [NPORT-1:0] w_masked;
  logic             w_any;
  logic [2:0]       w_win;

  always_comb begin
    w_hi_mask = '0;
    w_win     = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_hi_mask[i] = (i >= int'(r_rr_ptr));
    end
    w_masked = req_valid & w_hi_mask;
    w_any    = |req_valid;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (req_valid[i]) w_win = 3'(i);
    end
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (w_masked[i]) w_win = 3'(i);
    end
  end

  // Payload of the winning port
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_win == 3'(i)) begin
        w_sel_wr    = req_wr[i];
        w_sel_addr  = req_addr[AW*i +: AW];
        w_sel_wdata = req_wdata[DW*i +: DW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant / accept
  // Grant depends only on registered occupancy, never on l3_ready, so the
  // ready path to the cores stays short. Reset forces it low even though the
  // registered state already reads empty.
  // --------------------------------------------------------------------------
  logic w_can_grant;
  logic w_accept;
  logic w_in_range;
  logic w_push;
  logic w_pop;
  logic w_drop;

  always_comb begin
    w_can_grant = rst_n && w_any && (r_level != 2'd2);
    req_ready   = '0;
    for (int i = 0; i < NPORT; i++) begin
      req_ready[i] = w_can_grant && (w_win == 3'(i));
    end
  end

  assign w_accept   = |(req_valid & req_ready);
  assign w_in_range = (w_sel_addr[AW-1:c_HALF] < c_CELL_LIMIT) &&
                      (w_sel_addr[c_HALF-1:0]  < c_CELL_LIMIT);
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_pop      = l3_valid && l3_ready;

  // --------------------------------------------------------------------------
  // Round-robin pointer: moves just past the accepted port, else holds
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_win == c_LAST) ? 3'd0 : w_win + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry command queue, entry = {wr, addr, wdata, src}
  // A push can only happen when level < 2, so a simultaneous pop never races
  // a full queue; push+pop leaves the level unchanged.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_level  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_sel_wr, w_sel_addr, w_sel_wdata, w_win};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 2'd1;
        2'b01:   r_level <= r_level - 2'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Drop reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_err_pulse <= w_drop;
      if (w_drop && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: payload is zeroed while the queue is empty so that stale
  // entries never appear on the L3 port.
  // --------------------------------------------------------------------------
  logic [c_ENT_W-1:0] w_head;

  assign w_head     = l3_valid ? r_mem[r_rd_ptr] : '0;
  assign l3_valid   = (r_level != 2'd0);
  assign l3_wr      = w_head[c_ENT_W-1];
  assign l3_addr    = w_head[DW+3 +: AW];
  assign l3_wdata   = w_head[3 +: DW];
  assign l3_src     = w_head[2:0];
  assign fifo_level = r_level;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire
